// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan capture block.
package ssd_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam int SMP_W = 11;

    localparam logic [3:0] CTL_DIGIT0 = 4'b1110;
    localparam logic [3:0] CTL_DIGIT1 = 4'b1101;
    localparam logic [3:0] CTL_DIGIT2 = 4'b1011;
    localparam logic [3:0] CTL_DIGIT3 = 4'b0111;
    localparam logic [3:0] CTL_BLANK  = 4'b1111;

    typedef struct packed {
        logic       legal;
        logic       blank;
        digit_idx_t idx;
    } ctl_dec_t;

    function automatic ctl_dec_t decode_ctl(input logic [3:0] ctl);
        ctl_dec_t dec;
        // NOTE: every field gets a default before the case so a missing arm can never leave a value unassigned (the same rule keeps always_comb latch-free).
        dec = '0;
        case (ctl)
            CTL_DIGIT0: begin dec.legal = 1'b1; dec.idx = 2'd0; end
            CTL_DIGIT1: begin dec.legal = 1'b1; dec.idx = 2'd1; end
            CTL_DIGIT2: begin dec.legal = 1'b1; dec.idx = 2'd2; end
            CTL_DIGIT3: begin dec.legal = 1'b1; dec.idx = 2'd3; end
            CTL_BLANK:  dec.blank = 1'b1;
            default:    ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/ssd_capture_if.sv
// Display-scan bus: enable/segment inputs and captured digit outputs.
interface ssd_capture_if;

    logic [3:0] ssd_ctl;
    logic [6:0] ssd_in;
    logic [6:0] digit0;
    logic [6:0] digit1;
    logic [6:0] digit2;
    logic [6:0] digit3;
    logic [3:0] digit_valid;
    logic       frame_done;
    logic       err_ctl;
    logic       err_order;

    modport master (
        output ssd_ctl, ssd_in,
        input  digit0, digit1, digit2, digit3, digit_valid,
        input  frame_done, err_ctl, err_order
    );

    modport slave (
        input  ssd_ctl, ssd_in,
        output digit0, digit1, digit2, digit3, digit_valid,
        output frame_done, err_ctl, err_order
    );

endinterface

// File: rtl/ssd_stable_filter.sv
// Two-flop synchronizer plus stability counter; capture fires once per stable hold.
module ssd_stable_filter
    import ssd_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SMP_W-1:0] raw,
    output logic [SMP_W-1:0] s,
    output logic             capture
);

    localparam logic [7:0] CNT_SAT = 8'(STABLE_CYC);
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 1);

    logic [SMP_W-1:0] sync1;
    logic [SMP_W-1:0] sync2;
    logic [SMP_W-1:0] s_prev;
    logic [7:0]       cnt;
    logic [2:0]       fill;

    // fill[2] marks that s_prev holds a real post-reset sample, so the zeroed
    // pipeline can never be mistaken for a stable input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            s_prev <= '0;
            cnt    <= '0;
            fill   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values, which is what makes this a shift chain.
            sync1  <= raw;
            sync2  <= sync1;
            s_prev <= sync2;
            fill   <= {fill[1:0], 1'b1};
            if (!fill[2] || (sync2 != s_prev)) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign s       = sync2;
    assign capture = fill[2] && (sync2 == s_prev) && (cnt == CNT_CAP);

endmodule

// File: rtl/ssd_capture.sv
// Captures multiplexed seven-segment digits into per-digit registers.
// Optional scan-order checking is enabled by defining SSD_CAPTURE_ORDER_CHECK_EN.
module ssd_capture
    import ssd_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input logic          clk,
    input logic          rst_n,
    ssd_capture_if.slave bus
);

    logic [SMP_W-1:0] smp;
    logic             capture;
    ctl_dec_t         dec;
    logic [3:0]       seen;
    logic [3:0]       seen_next;
    logic [3:0][6:0]  digit_q;
    logic [3:0]       valid_q;
    logic             frame_q;
    logic             err_ctl_q;

    ssd_stable_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     ({bus.ssd_ctl, bus.ssd_in}),
        .s       (smp),
        .capture (capture)
    );

    assign dec       = decode_ctl(smp[10:7]);
    assign seen_next = seen | (4'b0001 << dec.idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the digit storage is reset explicitly because its zero state is architecturally visible.
            digit_q   <= '0;
            valid_q   <= '0;
            seen      <= '0;
            frame_q   <= 1'b0;
            err_ctl_q <= 1'b0;
        end else begin
            frame_q   <= 1'b0;
            err_ctl_q <= 1'b0;
            if (capture) begin
                if (dec.legal) begin
                    digit_q[dec.idx] <= smp[6:0];
                    valid_q[dec.idx] <= 1'b1;
                    // Completing the frame restarts the mask in the same cycle.
                    if (seen_next == 4'hF) begin
                        frame_q <= 1'b1;
                        seen    <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                end else if (!dec.blank) begin
                    err_ctl_q <= 1'b1;
                end
            end
        end
    end

`ifdef SSD_CAPTURE_ORDER_CHECK_EN
    digit_idx_t last_idx;
    logic       have_last;
    logic       err_order_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx    <= '0;
            have_last   <= 1'b0;
            err_order_q <= 1'b0;
        end else if (capture && dec.legal) begin
            if (have_last && (dec.idx != last_idx + 2'd1)) begin
                err_order_q <= 1'b1;
            end
            last_idx  <= dec.idx;
            have_last <= 1'b1;
        end
    end

    assign bus.err_order = err_order_q;
`else
    assign bus.err_order = 1'b0;
`endif

    assign bus.digit0      = digit_q[0];
    assign bus.digit1      = digit_q[1];
    assign bus.digit2      = digit_q[2];
    assign bus.digit3      = digit_q[3];
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.err_ctl     = err_ctl_q;

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, is the number of consecutive equal synchronized samples required before a capture; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ssd_ctl  input  4  digit enable, one-hot-low: 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3, 1111=blank.
REQ-005 ssd_in  input  7  value driven for the enabled digit.
REQ-006 digit0, digit1, digit2, digit3  output  7 each  last captured value per digit.
REQ-007 digit_valid  output  4  bit N is set once digitN has been captured since reset.
REQ-008 frame_done  output  1  one-cycle pulse when all four digits have been captured in the current frame.
REQ-009 err_ctl  output  1  one-cycle pulse on a stable illegal ssd_ctl pattern.
REQ-010 err_order  output  1  sticky scan-order error flag.

Function
REQ-011 ssd_ctl and ssd_in shall pass through a two-flop synchronizer; the 11-bit second-stage value is the sample s.
REQ-012 A register s_prev shall load s every cycle.
REQ-013 A saturating 8-bit counter cnt shall clear when s != s_prev; otherwise it increments, saturating at STABLE_CYC.
REQ-014 A capture event shall occur when s == s_prev and cnt == STABLE_CYC-1.
- Output latency: STABLE_CYC+3 rising edges after the input change edge.
- Only one capture per stable hold; no re-capture while held.
REQ-015 On a capture with a legal one-hot-low ssd_ctl, the block shall:
- load ssd_in into the matching digitN;
- set digit_valid[N];
- set bit N of the internal frame mask seen[3:0].
REQ-016 On a capture with ssd_ctl == 1111, the block shall not change any state and shall not raise an error.
REQ-017 On a capture with any other ssd_ctl pattern, err_ctl shall pulse for one cycle and no digit, mask or order state shall change.
REQ-018 When a capture makes seen == 1111, frame_done shall pulse in the cycle the digit updates, and seen shall clear in that same cycle.
REQ-019 A digit recaptured before the frame completes shall overwrite digitN; seen is unchanged.
REQ-020 Input glitches shorter than STABLE_CYC+1 samples shall never cause a capture.

Reset
REQ-021 While rst_n is low, all of the following shall be 0, asynchronously: digits, digit_valid, frame_done, err_ctl, err_order, seen, cnt, s_prev, synchronizer flops and the order tracker.
REQ-022 Reset asserted mid-hold shall discard the partial count; after release, a full STABLE_CYC+3 latency applies again.

Configuration
REQ-023 Macro SSD_CAPTURE_ORDER_CHECK_EN controls scan-order checking.
- When defined: every legal capture after the first since reset shall have index equal to the previous legal capture's index +1 mod 4; otherwise err_order sets and stays set until reset.
- When undefined: the order tracker is absent and err_order is tied to 0.

Structure
REQ-024 Package ssd_pkg shall hold:
- the digit-index type (2 bits);
- the four enable constants and the blank constant;
- a function mapping ssd_ctl to {legal, blank, index}.
REQ-025 The synchronizer, s_prev and cnt logic shall form sub-module ssd_stable_filter, with output {s, capture}.

Verification
REQ-026 Reset, then hold ssd_ctl=1110, ssd_in=7'h05 from edge 10 with STABLE_CYC=4 -> digit0=7'h05 and digit_valid=0001 after edge 17, not before.
REQ-027 Scan 1110/05, 1101/03, 1011/02, 0111/01, each held 8 cycles -> frame_done pulses once on the digit3 update, digit3..0=01,02,03,05, seen clears.
REQ-028 Hold 1110/09 for only 3 cycles, then 1111 -> no digit change, no error.
REQ-029 Hold ssd_ctl=1100 for 8 cycles -> err_ctl pulses exactly once, digits unchanged.
REQ-030 With SSD_CAPTURE_ORDER_CHECK_EN defined, scan digit0 then digit2 -> err_order=1 and stays 1 until rst_n low; with the macro undefined, err_order stays 0.
REQ-031 Assert rst_n low at cnt=2 during a digit1 hold, then release with the input unchanged -> all outputs 0 during reset; digit1 captured STABLE_CYC+3 edges after release.
